scroll_ctrl: RTL and testbench
==============================

Name: scroll_ctrl

Overview:
- Command generator for the 16-bit rotating panel register; drives its ch0/ch1 mode lines.
- Converts three raw push-buttons into one-cycle shift/load commands at a programmable scroll rate.
- Also provides a blanking flag and a rotation-offset counter for the panel.
- Sits between the board buttons and the shift register; both share CLK.

Parameters:
- DEB_CYCLES, 50000: consecutive stable samples required to accept a button level.
- STEP_DIV, 12500000: CLK cycles between scroll steps; must be ≥ 2.
- REG_LEN, 16: register length; sets the offset modulus.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- btn_para  in  1  raw "stop/reload" button, active-high, asynchronous to CLK.
- btn_dir_esq  in  1  raw "scroll right-to-left" button, active-high.
- btn_esq_dir  in  1  raw "scroll left-to-right" button, active-high.
- ch0  out  1  register mode bit 0.
- ch1  out  1  register mode bit 1.
- blank  out  1  1 = panel LEDs forced off.
- pos  out  $clog2(REG_LEN)  current rotation offset.
- step  out  1  one-cycle strobe coincident with every non-hold command.

Behaviour:
- Mode encoding {ch1,ch0}:
  - 00 = hold.
  - 01 = dir_esq (take previous bit).
  - 10 = esq_dir (take next bit).
  - 11 = para (load initial pattern).
- ch0/ch1 are registered outputs. They are 00 on every cycle except a command cycle; exactly one command cycle per event.
- Input synchronisation: each button passes through a 2-FF synchroniser, then a debouncer. Debounced level changes only after DEB_CYCLES consecutive equal samples.
- A press is the debounced rising edge. Holding a button produces no further events.
- Priority for same-cycle presses: para > dir_esq > esq_dir.
- FSM states:
  - INIT: entered on reset. Next cycle emits 11, sets pos=0, goes to PARADO.
  - PARADO: blank=1, no steps.
    - dir_esq press → DIR_ESQ.
    - esq_dir press → ESQ_DIR.
    - para press → LOAD.
  - DIR_ESQ / ESQ_DIR: blank=0. Prescaler counts 0..STEP_DIV-1; on wrap, emits 01 (DIR_ESQ) or 10 (ESQ_DIR) for one cycle.
    - Opposite-direction press: switch state and clear the prescaler.
    - Same-direction press: ignored; prescaler not disturbed.
    - para press → LOAD.
  - LOAD: emits 11 for one cycle, pos=0, then PARADO.
- A para press preempts a step due in the same cycle; the step is dropped.
- pos arithmetic:
  - dir_esq step: pos = (pos+1) mod REG_LEN.
  - esq_dir step: pos = (pos-1) mod REG_LEN; 0 → REG_LEN-1 on decrement.
  - load: pos = 0.
- First step after entering a direction state occurs STEP_DIV cycles after entry.
- Reset values: state INIT, ch0=0, ch1=0, step=0, blank=1, pos=0, prescaler=0, debounced levels=0, synchronisers=0.
- Reset asserted mid-step truncates the command immediately: ch0/ch1 go to 00 asynchronously.

Optional Feature:
- Macro: SCROLL_CTRL_AUTO_REVERSE_EN.
- Defined:
  - In a direction state, a bounce counter counts steps.
  - After REG_LEN-7 (=9) consecutive steps, direction flips automatically and the counter clears, so the 7-column window bounces across the pattern.
  - A button-initiated direction change or load also clears the counter.
- Undefined: no bounce counter; scrolling rotates indefinitely.

Decomposition:
- Shared package scroll_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_DIR_ESQ=2'b01, MODE_ESQ_DIR=2'b10, MODE_PARA=2'b11;
  - FSM state enum {INIT, PARADO, DIR_ESQ, ESQ_DIR, LOAD};
  - panel width constant COLS=7.
- One sub-module, btn_debounce: synchroniser, stable counter, debounced level and rising-edge pulse. Instantiated three times.

Test Plan:
- Bench uses DEB_CYCLES=4, STEP_DIV=8.
- Reset release → one cycle of {ch1,ch0}=11, then 00; blank=1; pos=0; step pulses once.
- btn_dir_esq high for 10 cycles → after debounce, state DIR_ESQ, blank=0; then 01 strobes exactly every 8 cycles. After 17 strobes pos=1 (16 wraps to 0).
- From pos=0 in ESQ_DIR, one step → pos=15, {ch1,ch0}=10 for exactly one cycle.
- btn_dir_esq and btn_para rise in the same cycle → LOAD wins: single 11 cycle, pos=0, PARADO, no 01 ever emitted.
- Button glitch high for 3 cycles (< DEB_CYCLES) → no state change, ch stays 00.
- With SCROLL_CTRL_AUTO_REVERSE_EN: in DIR_ESQ, 9 strobes of 01 followed by strobes of 10, pos sequence 0..9 then 8,7,…

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared mode encodings, FSM states and panel geometry for scroll_ctrl.
package scroll_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_DIR_ESQ = 2'b01;
    localparam logic [1:0] MODE_ESQ_DIR = 2'b10;
    localparam logic [1:0] MODE_PARA    = 2'b11;

    localparam int COLS = 7;

    typedef enum logic [2:0] {
        INIT,
        PARADO,
        DIR_ESQ,
        ESQ_DIR,
        LOAD
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample counter and
// a one-cycle pulse when the debounced level rises.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            // Any sample matching the current level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Button-driven shift/load command generator for the rotating panel.
// Define SCROLL_CTRL_AUTO_REVERSE_EN for automatic bounce scrolling.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int STEP_DIV   = 12500000,
    parameter int REG_LEN    = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       btn_para,
    input  logic                       btn_dir_esq,
    input  logic                       btn_esq_dir,
    output logic                       ch0,
    output logic                       ch1,
    output logic                       blank,
    output logic [$clog2(REG_LEN)-1:0] pos,
    output logic                       step
);

    localparam int PW = $clog2(REG_LEN);
    localparam int SW = $clog2(STEP_DIV);

    state_t        state, state_n;
    logic [SW-1:0] presc, presc_n;
    logic [PW-1:0] pos_n;
    logic [1:0]    cmd;
    logic          p_para, p_de, p_ed;
    logic          wrap, flip, keep_de, keep_ed;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_para (
        .clk(CLK), .rst(RST), .btn(btn_para), .press(p_para)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_de (
        .clk(CLK), .rst(RST), .btn(btn_dir_esq), .press(p_de)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ed (
        .clk(CLK), .rst(RST), .btn(btn_esq_dir), .press(p_ed)
    );

    assign wrap    = (presc == SW'(STEP_DIV - 1));
    // Stay in the current direction unless a higher-priority press wins.
    assign keep_de = !p_para && !(p_ed && !p_de);
    assign keep_ed = !p_para && !p_de;

`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
    localparam int BW = $clog2(REG_LEN - COLS) + 1;
    logic [BW-1:0] bcnt, bcnt_n;
    assign flip = wrap && (bcnt == BW'(REG_LEN - COLS - 1));
`else
    assign flip = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT;
            presc <= '0;
            pos   <= '0;
            ch0   <= 1'b0;
            ch1   <= 1'b0;
            step  <= 1'b0;
            blank <= 1'b1;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
            bcnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            pos        <= pos_n;
            {ch1, ch0} <= cmd;
            step       <= (cmd != MODE_HOLD);
            blank      <= !(state_n == DIR_ESQ || state_n == ESQ_DIR);
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
            bcnt       <= bcnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            INIT:    state_n = PARADO;
            PARADO: begin
                if (p_para)     state_n = LOAD;
                else if (p_de)  state_n = DIR_ESQ;
                else if (p_ed)  state_n = ESQ_DIR;
            end
            DIR_ESQ: begin
                if (p_para)                    state_n = LOAD;
                else if ((p_ed && !p_de) || flip) state_n = ESQ_DIR;
            end
            ESQ_DIR: begin
                if (p_para)             state_n = LOAD;
                else if (p_de || flip)  state_n = DIR_ESQ;
            end
            LOAD:    state_n = PARADO;
            default: state_n = INIT;
        endcase
    end

    always_comb begin
        cmd     = MODE_HOLD;
        presc_n = '0;
        pos_n   = pos;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
        bcnt_n  = '0;
`endif
        unique case (state)
            INIT, LOAD: begin
                cmd   = MODE_PARA;
                pos_n = '0;
            end
            DIR_ESQ: begin
                if (keep_de) begin
                    presc_n = wrap ? '0 : presc + 1'b1;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
                    bcnt_n  = bcnt;
`endif
                    if (wrap) begin
                        cmd   = MODE_DIR_ESQ;
                        pos_n = (pos == PW'(REG_LEN - 1)) ? '0 : pos + 1'b1;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
                        bcnt_n = flip ? '0 : bcnt + 1'b1;
`endif
                    end
                end
            end
            ESQ_DIR: begin
                if (keep_ed) begin
                    presc_n = wrap ? '0 : presc + 1'b1;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
                    bcnt_n  = bcnt;
`endif
                    if (wrap) begin
                        cmd   = MODE_ESQ_DIR;
                        pos_n = (pos == '0) ? PW'(REG_LEN - 1) : pos - 1'b1;
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
                        bcnt_n = flip ? '0 : bcnt + 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl: randomized button sessions against
// an event-level model of the scroll rules.
module tb_scroll_ctrl;

    localparam int DEB = 4;
    localparam int SD  = 8;
    localparam int RL  = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       bp = 1'b0, bd = 1'b0, be = 1'b0;
    logic       ch0, ch1, blank, step;
    logic [3:0] pos;

    always #5 CLK = ~CLK;

    scroll_ctrl #(.DEB_CYCLES(DEB), .STEP_DIV(SD), .REG_LEN(RL)) dut (
        .CLK(CLK), .RST(RST),
        .btn_para(bp), .btn_dir_esq(bd), .btn_esq_dir(be),
        .ch0(ch0), .ch1(ch1), .blank(blank), .pos(pos), .step(step)
    );

    typedef struct {
        logic [1:0] mode;
        int         pos;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   seen = 0, pushed = 0, cyc = 0;
    bit   abort = 0;

    // Model: md 0 = stopped, 1 = right-to-left, 2 = left-to-right.
    int md = 0, mpos = 0, bc = 0;
    bit fresh = 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic void push(logic [1:0] m, int p, int g);
        exp_t e;
        e.mode = m;
        e.pos  = p;
        e.gap  = g;
        q.push_back(e);
        pushed++;
    endfunction

    function automatic void mstep();
        int g;
        g = fresh ? 0 : SD;
        fresh = 0;
        if (md == 1) begin
            mpos = (mpos + 1) % RL;
            push(2'b01, mpos, g);
        end else begin
            mpos = (mpos + RL - 1) % RL;
            push(2'b10, mpos, g);
        end
`ifdef SCROLL_CTRL_AUTO_REVERSE_EN
        bc++;
        if (bc == RL - 7) begin
            bc = 0;
            md = 3 - md;
        end
`endif
    endfunction

    function automatic void msteps(int n);
        for (int i = 0; i < n; i++) mstep();
    endfunction

    function automatic void mload();
        md = 0; mpos = 0; bc = 0; fresh = 1;
        push(2'b11, 0, 0);
    endfunction

    function automatic void mgo(int d);
        md = d; bc = 0; fresh = 1;
    endfunction

    // Monitor: pops one expectation per command cycle.
    int       last_cyc = 0, fall_cyc = 0;
    bit       fpend = 0, pblank = 1;
    exp_t     me;
    logic [1:0] mm;
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                mm = {ch1, ch0};
                if (pblank && !blank) begin
                    fall_cyc = cyc;
                    fpend = 1;
                end
                pblank = blank;
                if (mm != 2'b00) begin
                    seen++;
                    chk("step_on_cmd", int'(step), 1);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd actual %0d required none (cyc %0d)",
                                 mm, cyc);
                    end else begin
                        me = q.pop_front();
                        chk("mode", int'(mm), int'(me.mode));
                        chk("pos", int'(pos), me.pos);
                        chk("blank", int'(blank), (me.mode == 2'b11) ? 1 : 0);
                        if (me.gap != 0)
                            chk("step_gap", cyc - last_cyc, me.gap);
                        if (fpend && mm != 2'b11)
                            chk("first_step_gap", cyc - fall_cyc, SD);
                    end
                    fpend = 0;
                    last_cyc = cyc;
                end else begin
                    chk("step_idle", int'(step), 0);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_seen(int target);
        int t;
        t = 0;
        while (seen < target && t < 400) begin
            tick(1);
            t++;
        end
        if (seen < target) begin
            checks++;
            errors++;
            $display("FAIL timeout actual %0d required %0d commands", seen, target);
            abort = 1;
        end
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0: bp = v;
            1: bd = v;
            default: be = v;
        endcase
    endtask

    task automatic release_all();
        bp = 1'b0; bd = 1'b0; be = 1'b0;
    endtask

    // Lands a press mid-way between the last two queued steps.
    task automatic slot();
        wait_seen(pushed - 1);
        tick(4);
    endtask

    task automatic start(int d, int n);
        wait_seen(pushed);
        tick(3);
        set_btn(d, 1'b1);
        mgo(d);
        msteps(n);
        tick(8);
        release_all();
    endtask

    task automatic idle_load(bit with_dir);
        wait_seen(pushed);
        tick(3);
        bp = 1'b1;
        if (with_dir) bd = 1'b1;
        mload();
        tick(8);
        release_all();
    endtask

    task automatic idle_glitch(int b);
        wait_seen(pushed);
        tick(3);
        set_btn(b, 1'b1);
        tick(3);
        release_all();
        tick(12);
    endtask

    task automatic run_op(int r, int n);
        int d;
        slot();
        case (r)
            0: begin
                bp = 1'b1;
                if ($urandom_range(0, 1) == 1) set_btn(int'($urandom_range(1, 2)), 1'b1);
                mload();
                tick(8);
            end
            1: begin
                d = 3 - md;
                set_btn(d, 1'b1);
                mgo(d);
                msteps(n);
                tick(8);
            end
            2: begin
                set_btn(md, 1'b1);
                msteps(n);
                tick(8);
            end
            default: begin
                set_btn(int'($urandom_range(0, 2)), 1'b1);
                tick(3);
                msteps(n);
            end
        endcase
        release_all();
    endtask

    int r;

    initial begin
        tick(3);
        chk("rst_ch", int'({ch1, ch0}), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_pos", int'(pos), 0);
        chk("rst_step", int'(step), 0);
        mload();
        RST = 1'b0;

        start(1, 17);
        run_op(0, 0);
        start(2, 2);
        if (!abort) begin
            slot();
            bd = 1'b1;
            bp = 1'b1;
            mload();
            tick(8);
            release_all();
        end
        idle_load(1'b1);
        for (int b = 0; b < 3; b++) idle_glitch(b);

        for (int k = 0; k < 25 && !abort; k++) begin
            if (md == 0) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0, 1: start(r + 1, int'($urandom_range(2, 12)));
                    2: idle_glitch(int'($urandom_range(0, 2)));
                    default: idle_load(1'b0);
                endcase
            end else begin
                run_op(int'($urandom_range(0, 3)), int'($urandom_range(2, 12)));
            end
        end

        if (!abort) begin
            if (md != 0) run_op(0, 0);
            start(1, 3);
            begin
                int t;
                t = 0;
                while (seen < pushed && t < 400) begin
                    @(negedge CLK);
                    #1;
                    t++;
                end
            end
            chk("pre_rst_cmd", int'({ch1, ch0}), 1);
            RST = 1'b1;
            #1;
            chk("async_trunc", int'({ch1, ch0}), 0);
            chk("rst_blank2", int'(blank), 1);
            chk("rst_pos2", int'(pos), 0);
            q.delete();
            md = 0; mpos = 0; bc = 0;
            tick(2);
            mload();
            RST = 1'b0;
            wait_seen(pushed);
            tick(20);
        end

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
